pipe_ctrl: RTL

- Central hazard and sequencing controller for the 5-stage MIPS pipeline.
- Drives the stall and flush controls of the F, D and E pipeline registers; flush_e feeds the execute-register clr input.
- Selects operand forwarding for the D and E stages.
- Runs a syscall drain/service state machine: when a syscall reaches E, the older instructions in M and W retire, then an external service unit is handshaked before fetch resumes.

---
 rtl/pipe_ctrl.sv | 150 +++++++++++++++
 1 files changed

// File: rtl/pipe_ctrl.sv
// Hazard/forwarding controller for the 5-stage pipeline plus syscall drain/service sequencer.
// Forwarding and hazard outputs are combinational; svc_req is registered and held until svc_done.
module pipe_ctrl #(
  parameter int DRAIN_CYCLES = 3,
  parameter int CNT_W        = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [4:0] rs_d,
  input  logic [4:0] rt_d,
  input  logic [4:0] rs_e,
  input  logic [4:0] rt_e,
  input  logic [4:0] write_reg_e,
  input  logic [4:0] write_reg_m,
  input  logic [4:0] write_reg_w,
  input  logic       reg_write_e,
  input  logic       reg_write_m,
  input  logic       reg_write_w,
  input  logic       mem_to_reg_e,
  input  logic       mem_to_reg_m,
  input  logic       branch_d,
  input  logic       pc_src_d,
  input  logic       jump_d,
  input  logic       syscall_e,
  input  logic       svc_done,
  output logic       stall_f,
  output logic       stall_d,
  output logic       flush_d,
  output logic       flush_e,
  output logic       fwd_a_d,
  output logic       fwd_b_d,
  output logic [1:0] fwd_a_e,
  output logic [1:0] fwd_b_e,
  output logic       svc_req,
  output logic       busy
);

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    DRAIN = 2'd1,
    SVC   = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DRAIN_CYCLES - 1);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             svc_req_q, svc_req_d;

  logic lw_stall, br_stall, hz;
  logic hold_c, flush_d_c;

  // E-stage forwarding: M result wins over W; register 0 never forwards.
  always_comb begin
    fwd_a_e = 2'b00;
    if (rs_e != 5'd0 && rs_e == write_reg_m && reg_write_m)
      fwd_a_e = 2'b10;
    else if (rs_e != 5'd0 && rs_e == write_reg_w && reg_write_w)
      fwd_a_e = 2'b01;
  end

  always_comb begin
    fwd_b_e = 2'b00;
    if (rt_e != 5'd0 && rt_e == write_reg_m && reg_write_m)
      fwd_b_e = 2'b10;
    else if (rt_e != 5'd0 && rt_e == write_reg_w && reg_write_w)
      fwd_b_e = 2'b01;
  end

  assign fwd_a_d = (rs_d != 5'd0) && (rs_d == write_reg_m) && reg_write_m;
  assign fwd_b_d = (rt_d != 5'd0) && (rt_d == write_reg_m) && reg_write_m;

  assign lw_stall = mem_to_reg_e && ((rt_e == rs_d) || (rt_e == rt_d));
  assign br_stall = branch_d &&
                    ((reg_write_e  && ((write_reg_e == rs_d) || (write_reg_e == rt_d))) ||
                     (mem_to_reg_m && ((write_reg_m == rs_d) || (write_reg_m == rt_d))));
  assign hz = lw_stall || br_stall;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    svc_req_d = svc_req_q;
    hold_c    = 1'b1;
    flush_d_c = 1'b0;
    case (state_q)
      RUN: begin
        cnt_d     = '0;
        svc_req_d = 1'b0;
        // A syscall in E outranks every other hazard: freeze F/D, bubble E.
        if (syscall_e) begin
          state_d = DRAIN;
        end else begin
          hold_c    = hz;
          flush_d_c = (pc_src_d || jump_d) && !hz;
        end
      end
      DRAIN: begin
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_LAST) begin
          state_d   = SVC;
          cnt_d     = '0;
          svc_req_d = 1'b1;
        end
      end
      SVC: begin
        svc_req_d = 1'b1;
        if (svc_done) begin
          state_d   = RUN;
          svc_req_d = 1'b0;
        end
      end
      default: begin
        state_d   = RUN;
        cnt_d     = '0;
        svc_req_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= RUN;
      cnt_q     <= '0;
      svc_req_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      svc_req_q <= svc_req_d;
    end
  end

  // While reset is held the pipeline registers are cleared, not frozen.
  always_comb begin
    if (!rst_n) begin
      stall_f = 1'b0;
      stall_d = 1'b0;
      flush_d = 1'b1;
      flush_e = 1'b1;
    end else begin
      stall_f = hold_c;
      stall_d = hold_c;
      flush_d = flush_d_c;
      flush_e = hold_c;
    end
  end

  assign svc_req = svc_req_q;
  assign busy    = (state_q != RUN);

endmodule
